// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl
//   Central stall/flush scheduler for the 5-stage pipeline. It arbitrates
//   load-use hazards, taken-branch redirects resolved in ID, and multi-cycle
//   data-memory accesses. It also owns the dmem start/ack handshake and a
//   timeout watchdog.
//
//   Optional macro STALL_PERF_CNT_EN adds three saturating 32-bit perf counters.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   hazard_stall_i     load-use stall request
//   branch_taken_i     taken branch/jump in ID
//   dmem_req_i         valid load/store in EX/MEM
//   dmem_ack_i         data memory finished the access
//   dmem_start_o       one-cycle launch pulse
//   *_stall_o/*_flush_o per-stage hold / bubble controls
//   busy_o             FSM in WAIT
//   timeout_o          sticky watchdog error
//   perf_*_o           (STALL_PERF_CNT_EN only) mem-freeze, hazard, flush cycles
//
// state | meaning
// RUN   | normal flow; hazards/branches handled, a dmem request launches access
// WAIT  | access in flight; full freeze until ack or watchdog expiry
module pipeline_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_stall_i,
  input  logic        branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ack_i,
  output logic        dmem_start_o,
  output logic        PC_stall_o,
  output logic        IFID_stall_o,
  output logic        IFID_flush_o,
  output logic        IDEX_stall_o,
  output logic        IDEX_flush_o,
  output logic        EXMEM_stall_o,
  output logic        MEMWB_flush_o,
  output logic        busy_o,
`ifdef STALL_PERF_CNT_EN
  output logic [31:0] perf_mem_o,
  output logic [31:0] perf_hazard_o,
  output logic [31:0] perf_flush_o,
`endif
  output logic        timeout_o
);

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;

  logic freeze;
  logic start;
  logic hz_stall;
  logic br_flush;
  logic out_en;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    freeze     = 1'b0;
    start      = 1'b0;
    hz_stall   = 1'b0;
    br_flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        // A memory request overrides hazard and branch handling entirely.
        if (dmem_req_i) begin
          start      = 1'b1;
          freeze     = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end else if (hazard_stall_i) begin
          hz_stall = 1'b1;
        end else if (branch_taken_i) begin
          br_flush = 1'b1;
        end
      end
      ST_WAIT: begin
        // An ack wins over a coincident watchdog expiry.
        if (dmem_ack_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TMO_LAST) begin
          timeout_d  = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          freeze     = 1'b1;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // All outputs are held low while reset is asserted, even mid-WAIT.
  assign out_en        = ~rst_i;
  assign dmem_start_o  = out_en & start;
  assign PC_stall_o    = out_en & (freeze | hz_stall);
  assign IFID_stall_o  = out_en & (freeze | hz_stall);
  assign IFID_flush_o  = out_en & br_flush;
  assign IDEX_stall_o  = out_en & freeze;
  assign IDEX_flush_o  = out_en & hz_stall;
  assign EXMEM_stall_o = out_en & freeze;
  assign MEMWB_flush_o = out_en & freeze;
  assign busy_o        = out_en & (state_q == ST_WAIT);
  assign timeout_o     = out_en & timeout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_hazard_q, perf_hazard_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    sat_inc = (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  always_comb begin
    perf_mem_d    = sat_inc(perf_mem_q, freeze);
    perf_hazard_d = sat_inc(perf_hazard_q, hz_stall);
    perf_flush_d  = sat_inc(perf_flush_q, br_flush);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_mem_q    <= '0;
      perf_hazard_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_mem_q    <= perf_mem_d;
      perf_hazard_q <= perf_hazard_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_mem_o    = perf_mem_q;
  assign perf_hazard_o = perf_hazard_q;
  assign perf_flush_o  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Testbench for pipeline_stall_ctrl. Two instances share stimulus: u_dut with
// the default watchdog and u_to with TIMEOUT=4 for the watchdog scenario.
// Output vector bit order:
//   9 start, 8 PC_stall, 7 IFID_stall, 6 IFID_flush, 5 IDEX_stall,
//   4 IDEX_flush, 3 EXMEM_stall, 2 MEMWB_flush, 1 busy, 0 timeout
module tb_pipeline_stall_ctrl;

  localparam logic [9:0] V_Z     = 10'b00_0000_0000;
  localparam logic [9:0] V_ENTRY = 10'b11_1010_1100;
  localparam logic [9:0] V_WAIT  = 10'b01_1010_1110;
  localparam logic [9:0] V_ACK   = 10'b00_0000_0010;
  localparam logic [9:0] V_HAZ   = 10'b01_1001_0000;
  localparam logic [9:0] V_BR    = 10'b00_0100_0000;
  localparam logic [9:0] V_TO    = 10'b00_0000_0001;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic hazard_stall_i = 1'b0;
  logic branch_taken_i = 1'b0;
  logic dmem_req_i = 1'b0;
  logic dmem_ack_i = 1'b0;

  logic a_start, a_pc, a_ifs, a_iff, a_ids, a_idf, a_ems, a_mwf, a_busy, a_to;
  logic b_start, b_pc, b_ifs, b_iff, b_ids, b_idf, b_ems, b_mwf, b_busy, b_to;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] a_pm, a_ph, a_pf, b_pm, b_ph, b_pf;
`endif

  always #5 clk = ~clk;

  pipeline_stall_ctrl u_dut (
    .clk_i(clk), .rst_i(rst_i),
    .hazard_stall_i(hazard_stall_i), .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .dmem_start_o(a_start), .PC_stall_o(a_pc),
    .IFID_stall_o(a_ifs), .IFID_flush_o(a_iff),
    .IDEX_stall_o(a_ids), .IDEX_flush_o(a_idf),
    .EXMEM_stall_o(a_ems), .MEMWB_flush_o(a_mwf),
    .busy_o(a_busy),
`ifdef STALL_PERF_CNT_EN
    .perf_mem_o(a_pm), .perf_hazard_o(a_ph), .perf_flush_o(a_pf),
`endif
    .timeout_o(a_to)
  );

  pipeline_stall_ctrl #(.TIMEOUT(4), .CNT_W(8)) u_to (
    .clk_i(clk), .rst_i(rst_i),
    .hazard_stall_i(hazard_stall_i), .branch_taken_i(branch_taken_i),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .dmem_start_o(b_start), .PC_stall_o(b_pc),
    .IFID_stall_o(b_ifs), .IFID_flush_o(b_iff),
    .IDEX_stall_o(b_ids), .IDEX_flush_o(b_idf),
    .EXMEM_stall_o(b_ems), .MEMWB_flush_o(b_mwf),
    .busy_o(b_busy),
`ifdef STALL_PERF_CNT_EN
    .perf_mem_o(b_pm), .perf_hazard_o(b_ph), .perf_flush_o(b_pf),
`endif
    .timeout_o(b_to)
  );

  logic [9:0] obs_a, obs_b;
  assign obs_a = {a_start, a_pc, a_ifs, a_iff, a_ids, a_idf, a_ems, a_mwf, a_busy, a_to};
  assign obs_b = {b_start, b_pc, b_ifs, b_iff, b_ids, b_idf, b_ems, b_mwf, b_busy, b_to};

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] exp_q[$];
  string       tag_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected vector, then compare the
  // selected instance's outputs mid-cycle.
  task automatic cyc(input string tag, input logic r, input logic hz, input logic br,
                     input logic rq, input logic ak, input logic sel, input logic [9:0] exp);
    logic [10:0] e;
    string       t;
    logic [9:0]  o;
    @(posedge clk);
    #1;
    rst_i = r; hazard_stall_i = hz; branch_taken_i = br;
    dmem_req_i = rq; dmem_ack_i = ak;
    exp_q.push_back({sel, exp});
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = e[10] ? obs_b : obs_a;
    chk(t, {22'd0, o}, {22'd0, e[9:0]});
  endtask

  initial begin
    // Reset with a pending request: nothing asserts, then launch after release.
    cyc("rst_c1",        1, 0, 0, 1, 0, 0, V_Z);
    cyc("rst_c2",        1, 0, 0, 1, 0, 0, V_Z);
    cyc("rel_entry",     0, 0, 0, 1, 0, 0, V_ENTRY);
    cyc("rel_wait",      0, 0, 0, 1, 0, 0, V_WAIT);
    cyc("rst_midwait",   1, 0, 0, 1, 0, 0, V_Z);
    cyc("post_rst_entry",0, 0, 0, 1, 0, 0, V_ENTRY);
    cyc("post_rst_ack",  0, 0, 0, 0, 1, 0, V_ACK);
    cyc("idle1",         0, 0, 0, 0, 0, 0, V_Z);
    cyc("rst_s2",        1, 0, 0, 0, 0, 0, V_Z);

    // Access acked after four frozen WAIT cycles: five freeze cycles total.
    cyc("s2_entry",      0, 0, 0, 1, 0, 0, V_ENTRY);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("s2_wait%0d", i), 0, 0, 0, 1, 0, 0, V_WAIT);
    cyc("s2_ack",        0, 0, 0, 0, 1, 0, V_ACK);
    cyc("s2_idle",       0, 0, 0, 0, 0, 0, V_Z);
`ifdef STALL_PERF_CNT_EN
    chk("perf_mem_s2", a_pm, 32'd5);
`endif

    // Hazard beats branch, then a lone branch; ack in RUN is ignored.
    cyc("haz_br",        0, 1, 1, 0, 0, 0, V_HAZ);
    cyc("br_only",       0, 0, 1, 0, 0, 0, V_BR);
    cyc("ack_in_run",    0, 0, 0, 0, 1, 0, V_Z);
`ifdef STALL_PERF_CNT_EN
    chk("perf_mem",      a_pm, 32'd5);
    chk("perf_hazard",   a_ph, 32'd1);
    chk("perf_flush",    a_pf, 32'd1);
`endif
    // Memory request overrides hazard and branch; ack drops every control.
    cyc("req_over_haz",  0, 1, 1, 1, 0, 0, V_ENTRY);
    cyc("ack_haz_ign",   0, 1, 1, 0, 1, 0, V_ACK);
    cyc("idle2",         0, 0, 0, 0, 0, 0, V_Z);

    // Back-to-back accesses with req held high.
    cyc("b2b_entry1",    0, 0, 0, 1, 0, 0, V_ENTRY);
    cyc("b2b_wait1",     0, 0, 0, 1, 0, 0, V_WAIT);
    cyc("b2b_ack1",      0, 0, 0, 1, 1, 0, V_ACK);
    cyc("b2b_entry2",    0, 0, 0, 1, 0, 0, V_ENTRY);
    cyc("b2b_wait2a",    0, 0, 0, 1, 0, 0, V_WAIT);
    cyc("b2b_wait2b",    0, 0, 0, 1, 0, 0, V_WAIT);
    cyc("b2b_ack2",      0, 0, 0, 0, 1, 0, V_ACK);
    cyc("idle3",         0, 0, 0, 0, 0, 0, V_Z);

    // Watchdog on the TIMEOUT=4 instance.
    cyc("to_rst",        1, 0, 0, 0, 0, 1, V_Z);
    cyc("to_entry",      0, 0, 0, 1, 0, 1, V_ENTRY);
    for (int i = 0; i < 3; i++)
      cyc($sformatf("to_wait%0d", i), 0, 0, 0, 1, 0, 1, V_WAIT);
    cyc("to_expire",     0, 0, 0, 1, 0, 1, V_ACK);
    cyc("to_flag",       0, 0, 0, 0, 1, 1, V_TO);
    cyc("to_sticky",     0, 0, 0, 0, 0, 1, V_TO);
    cyc("to_reentry",    0, 0, 0, 1, 0, 1, V_ENTRY | V_TO);
    cyc("to_clear",      1, 0, 0, 0, 0, 1, V_Z);
    cyc("to_cleared",    0, 0, 0, 0, 0, 1, V_Z);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
